pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, the first fetch PC after reset.
REQ-002 SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port bpu_pc, output, 32 bits: current fetch PC presented to the predictor.
REQ-005 SHALL have ports bpu_next_pc (input, 32), bpu_pc_valid (input, 4) and bpu_pc_is_jump (input, 4): the predictor's combinational answer for bpu_pc.
REQ-006 SHALL have port install, output, 1 bit: high means bpu_pc is not accepted this cycle; the predictor does not record history.
REQ-007 SHALL have ports ex_redirect (input, 1) and ex_pc (input, 32): execute-stage flush and its target.
REQ-008 SHALL have ports bpu_flush (input, 1) and bpu_jump_pc (input, 32): predictor mispredict correction.
REQ-009 SHALL have ports id_flush (input, 1) and id_pc (input, 32): decode-stage redirect.
REQ-010 SHALL have icache ports icache_req (output, 1), icache_addr (output, 32), icache_addr_ok (input, 1), icache_data_ok (input, 1) and icache_rdata (input, 128).
REQ-011 SHALL have fetch-queue ports fq_valid (output, 1), fq_ready (input, 1), fq_pc (output, 32), fq_mask (output, 4), fq_jump (output, 4) and fq_inst (output, 128).

Function
REQ-012 SHALL keep at most one icache request outstanding.
REQ-013 SHALL implement FSM states REQ, WAIT and HOLD.
- REQ: icache_req=1; on icache_addr_ok, go to WAIT.
- WAIT: on icache_data_ok, go to HOLD.
- HOLD: fq_valid=1; when fq_ready=1, go to REQ.
REQ-014 SHALL drive icache_addr = {pc[31:4], 4'b0} and bpu_pc = pc.
REQ-015 SHALL, on the addr_ok handshake, load pc <= bpu_next_pc and latch {pc, bpu_pc_valid, bpu_pc_is_jump} into the in-flight slot.
REQ-016 SHALL present the in-flight slot on fq_pc/fq_mask/fq_jump, and icache_rdata (captured at data_ok) on fq_inst, in HOLD.
REQ-017 SHALL drive install = !(state==REQ && icache_addr_ok) || any redirect.
REQ-018 SHALL select the redirect target by priority ex_redirect > bpu_flush > id_flush.
REQ-019 SHALL, on a redirect, set pc <= the selected target that cycle and suppress the addr_ok pc update.
REQ-020 SHALL, on a redirect in REQ, remain in REQ; a coincident addr_ok is treated as accepted but killed, so the FSM goes to WAIT with the kill flag set.
REQ-021 SHALL, on a redirect in WAIT, set the kill flag; the next data_ok is discarded (no HOLD) and the FSM goes to REQ.
REQ-022 SHALL, on a redirect in HOLD, drop the group (fq_valid=0 next cycle) and go to REQ.
REQ-023 SHALL, when data_ok and a redirect coincide in WAIT, discard the data and go to REQ.
REQ-024 SHALL hold fq_valid=0 in every cycle a redirect is asserted.
REQ-025 SHALL hold all fq_* outputs stable while fq_valid=1 and fq_ready=0.
REQ-026 SHALL perform all PC arithmetic modulo 2^32 with no carry-out detection.

Reset
REQ-027 SHALL, on reset, set state=REQ, pc=RESET_PC, kill=0, fq_valid=0, fq_mask=0, fq_jump=0, fq_pc=0, fq_inst=0.
REQ-028 SHALL assert icache_req=1 with icache_addr=RESET_PC in the first cycle after reset deasserts.
REQ-029 SHALL, on reset mid-request, abandon the outstanding request; a later data_ok with kill=0 in REQ state is ignored.
REQ-030 SHALL clear any performance counters on reset.

Configuration
REQ-031 SHALL, when macro PCGEN_PERF_CNT_EN is defined, add 32-bit output ports perf_groups and perf_redirects.
- perf_groups increments on each fq_valid && fq_ready.
- perf_redirects increments on each cycle with any redirect.
- Both counters wrap at 2^32.
REQ-032 SHALL, when PCGEN_PERF_CNT_EN is undefined, have neither those ports nor the counter logic.

Verification
REQ-033 SHALL verify reset fetch: reset then addr_ok=1, data_ok next cycle, fq_ready=1 -> fq_pc=32'h1c000000, fq_mask=bpu_pc_valid as sampled, one group delivered.
REQ-034 SHALL verify prediction follow: bpu_next_pc=32'h1c000100 at handshake -> next icache_addr=32'h1c000100 and install=0 only in the handshake cycle.
REQ-035 SHALL verify WAIT kill: ex_redirect=1 with ex_pc=32'h1c000200 while in WAIT -> next data_ok discarded, fq_valid stays 0, next icache_addr=32'h1c000200.
REQ-036 SHALL verify priority: ex_redirect, bpu_flush and id_flush in the same cycle with targets 0x10/0x20/0x30 -> pc=32'h00000010.
REQ-037 SHALL verify backpressure: fq_ready=0 for 5 cycles in HOLD -> fq_* stable, icache_req=0; after fq_ready=1, the FSM returns to REQ.
REQ-038 SHALL verify counters: with PCGEN_PERF_CNT_EN, 3 delivered groups and 1 redirect -> perf_groups=3, perf_redirects=1.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-side bus bundle for pc_gen: branch predictor query, redirect
// sources, instruction-cache request channel and fetch-queue output.
// The master modport is the pc_gen side; slave is the surrounding pipeline.
interface pc_gen_if;
    // Predictor query: bpu_pc goes out, the answer comes back in the same cycle.
    logic [31:0]  bpu_pc;
    logic [31:0]  bpu_next_pc;
    logic [3:0]   bpu_pc_valid;
    logic [3:0]   bpu_pc_is_jump;
    logic         install;

    // Redirect sources, listed from highest to lowest priority.
    logic         ex_redirect;
    logic [31:0]  ex_pc;
    logic         bpu_flush;
    logic [31:0]  bpu_jump_pc;
    logic         id_flush;
    logic [31:0]  id_pc;

    // Instruction cache: address phase (req/addr_ok), then data phase (data_ok).
    logic         icache_req;
    logic [31:0]  icache_addr;
    logic         icache_addr_ok;
    logic         icache_data_ok;
    logic [127:0] icache_rdata;

    // Fetch queue: a group moves when fq_valid && fq_ready.
    logic         fq_valid;
    logic         fq_ready;
    logic [31:0]  fq_pc;
    logic [3:0]   fq_mask;
    logic [3:0]   fq_jump;
    logic [127:0] fq_inst;

    modport master (
        output bpu_pc, install,
        input  bpu_next_pc, bpu_pc_valid, bpu_pc_is_jump,
        input  ex_redirect, ex_pc, bpu_flush, bpu_jump_pc, id_flush, id_pc,
        output icache_req, icache_addr,
        input  icache_addr_ok, icache_data_ok, icache_rdata,
        output fq_valid, fq_pc, fq_mask, fq_jump, fq_inst,
        input  fq_ready
    );

    modport slave (
        input  bpu_pc, install,
        output bpu_next_pc, bpu_pc_valid, bpu_pc_is_jump,
        output ex_redirect, ex_pc, bpu_flush, bpu_jump_pc, id_flush, id_pc,
        input  icache_req, icache_addr,
        output icache_addr_ok, icache_data_ok, icache_rdata,
        input  fq_valid, fq_pc, fq_mask, fq_jump, fq_inst,
        output fq_ready
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator. Issues one 16-byte-aligned icache request at a
// time, follows the branch predictor's next-PC answer, applies pipeline
// redirects (ex > bpu > id) and hands each returned group to the fetch queue.
//
// Handshakes: a transfer happens on a rising clk edge where both sides are
// high -- icache_req && icache_addr_ok for the address phase, fq_valid &&
// fq_ready for the fetch queue. The data phase is a single-cycle data_ok pulse
// with no back-pressure. Offered fq_* values stay stable until accepted.
//
// Optional feature: define PCGEN_PERF_CNT_EN to add the perf_groups and
// perf_redirects counter outputs.
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    pc_gen_if.master    bus,
    output logic [1:0]  o_dbg_state
`ifdef PCGEN_PERF_CNT_EN
    ,
    output logic [31:0] perf_groups,
    output logic [31:0] perf_redirects
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // address phase offered to the icache
        S_WAIT = 2'd1,  // address accepted, waiting for data_ok
        S_HOLD = 2'd2   // group offered to the fetch queue
    } state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic           r_kill;      // in-flight request must be discarded on return
    logic           r_fq_valid;
    logic [31:0]    r_fq_pc;
    logic [3:0]     r_fq_mask;
    logic [3:0]     r_fq_jump;
    logic [127:0]   r_fq_inst;

    logic           w_redirect;
    logic [31:0]    w_target;
    logic           w_addr_hs;
    logic           w_fq_fire;

    assign w_redirect = bus.ex_redirect | bus.bpu_flush | bus.id_flush;
    assign w_addr_hs  = (r_state == S_REQ) && bus.icache_addr_ok;

    // Redirect target, oldest pipeline stage wins.
    always_comb begin
        w_target = bus.id_pc;
        if (bus.ex_redirect) begin
            w_target = bus.ex_pc;
        end else if (bus.bpu_flush) begin
            w_target = bus.bpu_jump_pc;
        end
    end

    assign bus.bpu_pc      = r_pc;
    assign bus.icache_addr = {r_pc[31:4], 4'b0000};
    assign bus.icache_req  = (r_state == S_REQ);
    // Predictor history is only recorded for a PC that is actually fetched.
    assign bus.install     = !w_addr_hs || w_redirect;

    // A redirect cycle never offers a group, even if one is being held.
    assign bus.fq_valid = r_fq_valid & ~w_redirect;
    assign bus.fq_pc    = r_fq_pc;
    assign bus.fq_mask  = r_fq_mask;
    assign bus.fq_jump  = r_fq_jump;
    assign bus.fq_inst  = r_fq_inst;

    assign w_fq_fire   = bus.fq_valid && bus.fq_ready;
    assign o_dbg_state = r_state;

    // Fetch FSM with PC, kill flag and the in-flight / output slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_fq_valid <= 1'b0;
            r_fq_pc    <= 32'h0;
            r_fq_mask  <= 4'h0;
            r_fq_jump  <= 4'h0;
            r_fq_inst  <= 128'h0;
        end else begin
            // A redirect overrides any predictor-driven PC update.
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_addr_hs) begin
                r_pc <= bus.bpu_next_pc;
            end

            case (r_state)
                S_REQ: begin
                    if (bus.icache_addr_ok) begin
                        // The cache has taken the address either way; a
                        // redirect only decides whether the reply is kept.
                        r_state <= S_WAIT;
                        r_kill  <= w_redirect;
                        if (!w_redirect) begin
                            r_fq_pc   <= r_pc;
                            r_fq_mask <= bus.bpu_pc_valid;
                            r_fq_jump <= bus.bpu_pc_is_jump;
                        end
                    end
                end

                S_WAIT: begin
                    if (bus.icache_data_ok) begin
                        r_kill <= 1'b0;
                        if (r_kill || w_redirect) begin
                            r_state <= S_REQ;
                        end else begin
                            r_state    <= S_HOLD;
                            r_fq_valid <= 1'b1;
                            r_fq_inst  <= bus.icache_rdata;
                        end
                    end else if (w_redirect) begin
                        r_kill <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (w_redirect || bus.fq_ready) begin
                        r_state    <= S_REQ;
                        r_fq_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= S_REQ;
                    r_kill     <= 1'b0;
                    r_fq_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PCGEN_PERF_CNT_EN
    logic [31:0] r_perf_groups;
    logic [31:0] r_perf_redirects;

    // Delivered-group and redirect-cycle counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_groups    <= 32'h0;
            r_perf_redirects <= 32'h0;
        end else begin
            if (w_fq_fire) begin
                r_perf_groups <= r_perf_groups + 32'd1;
            end
            if (w_redirect) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
        end
    end

    assign perf_groups    = r_perf_groups;
    assign perf_redirects = r_perf_redirects;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_fq_fire;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen. Each task drives one scenario and checks
// the outputs against hand-computed values. Define PCGEN_PERF_CNT_EN to
// include the counter scenario.
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic [1:0]  dbg_state;
    int          checks;
    int          failures;

`ifdef PCGEN_PERF_CNT_EN
    logic [31:0] perf_groups;
    logic [31:0] perf_redirects;
`endif

    pc_gen_if bus();

    pc_gen #(.RESET_PC(32'h1c000000)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .o_dbg_state    (dbg_state)
`ifdef PCGEN_PERF_CNT_EN
        ,
        .perf_groups    (perf_groups),
        .perf_redirects (perf_redirects)
`endif
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.bpu_next_pc    = 32'h0;
        bus.bpu_pc_valid   = 4'h0;
        bus.bpu_pc_is_jump = 4'h0;
        bus.ex_redirect    = 1'b0;
        bus.ex_pc          = 32'h0;
        bus.bpu_flush      = 1'b0;
        bus.bpu_jump_pc    = 32'h0;
        bus.id_flush       = 1'b0;
        bus.id_pc          = 32'h0;
        bus.icache_addr_ok = 1'b0;
        bus.icache_data_ok = 1'b0;
        bus.icache_rdata   = 128'h0;
        bus.fq_ready       = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Full fetch from REQ: handshake, data next cycle, accepted at once.
    task automatic deliver_group(input logic [31:0] next_pc, input logic [127:0] data);
        bus.icache_addr_ok = 1'b1;
        bus.bpu_next_pc    = next_pc;
        bus.bpu_pc_valid   = 4'hf;
        tick();
        bus.icache_addr_ok = 1'b0;
        bus.icache_data_ok = 1'b1;
        bus.icache_rdata   = data;
        tick();
        bus.icache_data_ok = 1'b0;
        bus.fq_ready       = 1'b1;
        tick();
        bus.fq_ready       = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL reset_fq_valid got=%0h exp=0", bus.fq_valid); end
        checks++; if (bus.fq_pc !== 32'h0) begin failures++; $display("FAIL reset_fq_pc got=%0h exp=0", bus.fq_pc); end
        checks++; if (bus.fq_mask !== 4'h0) begin failures++; $display("FAIL reset_fq_mask got=%0h exp=0", bus.fq_mask); end
        checks++; if (bus.fq_jump !== 4'h0) begin failures++; $display("FAIL reset_fq_jump got=%0h exp=0", bus.fq_jump); end
        checks++; if (bus.fq_inst !== 128'h0) begin failures++; $display("FAIL reset_fq_inst got=%0h exp=0", bus.fq_inst); end
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h1c000000) begin failures++; $display("FAIL reset_addr got=%0h exp=1c000000", bus.icache_addr); end
        checks++; if (bus.bpu_pc !== 32'h1c000000) begin failures++; $display("FAIL reset_bpu_pc got=%0h exp=1c000000", bus.bpu_pc); end
        checks++; if (bus.install !== 1'b1) begin failures++; $display("FAIL reset_install got=%0h exp=1", bus.install); end
    endtask

    // Reset fetch plus prediction follow.
    task automatic test_fetch_follow();
        bus.icache_addr_ok = 1'b1;
        bus.bpu_next_pc    = 32'h1c000100;
        bus.bpu_pc_valid   = 4'b1011;
        bus.bpu_pc_is_jump = 4'b0010;
        #1;
        checks++; if (bus.install !== 1'b0) begin failures++; $display("FAIL hs_install got=%0h exp=0", bus.install); end
        tick();
        bus.icache_addr_ok = 1'b0;
        bus.bpu_pc_valid   = 4'h0;
        bus.bpu_pc_is_jump = 4'h0;
        #1;
        checks++; if (bus.install !== 1'b1) begin failures++; $display("FAIL wait_install got=%0h exp=1", bus.install); end
        checks++; if (bus.icache_req !== 1'b0) begin failures++; $display("FAIL wait_req got=%0h exp=0", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h1c000100) begin failures++; $display("FAIL follow_addr got=%0h exp=1c000100", bus.icache_addr); end
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL wait_fq_valid got=%0h exp=0", bus.fq_valid); end
        bus.icache_data_ok = 1'b1;
        bus.icache_rdata   = 128'h0123456789abcdef_fedcba9876543210;
        tick();
        bus.icache_data_ok = 1'b0;
        bus.icache_rdata   = 128'h0;
        #1;
        checks++; if (bus.fq_valid !== 1'b1) begin failures++; $display("FAIL hold_fq_valid got=%0h exp=1", bus.fq_valid); end
        checks++; if (bus.fq_pc !== 32'h1c000000) begin failures++; $display("FAIL hold_fq_pc got=%0h exp=1c000000", bus.fq_pc); end
        checks++; if (bus.fq_mask !== 4'b1011) begin failures++; $display("FAIL hold_fq_mask got=%0h exp=b", bus.fq_mask); end
        checks++; if (bus.fq_jump !== 4'b0010) begin failures++; $display("FAIL hold_fq_jump got=%0h exp=2", bus.fq_jump); end
        checks++; if (bus.fq_inst !== 128'h0123456789abcdef_fedcba9876543210) begin failures++; $display("FAIL hold_fq_inst got=%0h", bus.fq_inst); end
        bus.fq_ready = 1'b1;
        tick();
        bus.fq_ready = 1'b0;
        #1;
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL after_fq_valid got=%0h exp=0", bus.fq_valid); end
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL after_req got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h1c000100) begin failures++; $display("FAIL after_addr got=%0h exp=1c000100", bus.icache_addr); end
    endtask

    // Redirect while waiting: the returning data is dropped.
    task automatic test_wait_kill();
        bus.icache_addr_ok = 1'b1;
        bus.bpu_next_pc    = 32'h1c000110;
        tick();
        bus.icache_addr_ok = 1'b0;
        bus.ex_redirect    = 1'b1;
        bus.ex_pc          = 32'h1c000200;
        #1;
        checks++; if (bus.install !== 1'b1) begin failures++; $display("FAIL kill_install got=%0h exp=1", bus.install); end
        tick();
        bus.ex_redirect    = 1'b0;
        bus.icache_data_ok = 1'b1;
        bus.icache_rdata   = {4{32'hdeadbeef}};
        tick();
        bus.icache_data_ok = 1'b0;
        #1;
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL kill_fq_valid got=%0h exp=0", bus.fq_valid); end
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL kill_req got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h1c000200) begin failures++; $display("FAIL kill_addr got=%0h exp=1c000200", bus.icache_addr); end
        tick();
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL kill_fq_valid2 got=%0h exp=0", bus.fq_valid); end
    endtask

    // Redirect source priority, applied in REQ without an address handshake.
    task automatic test_priority();
        bus.ex_redirect = 1'b1; bus.ex_pc       = 32'h10;
        bus.bpu_flush   = 1'b1; bus.bpu_jump_pc = 32'h20;
        bus.id_flush    = 1'b1; bus.id_pc       = 32'h30;
        tick();
        bus.ex_redirect = 1'b0;
        #1;
        checks++; if (bus.bpu_pc !== 32'h10) begin failures++; $display("FAIL prio_ex got=%0h exp=10", bus.bpu_pc); end
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL prio_req got=%0h exp=1", bus.icache_req); end
        tick();
        bus.bpu_flush = 1'b0;
        #1;
        checks++; if (bus.bpu_pc !== 32'h20) begin failures++; $display("FAIL prio_bpu got=%0h exp=20", bus.bpu_pc); end
        tick();
        bus.id_flush = 1'b0;
        #1;
        checks++; if (bus.bpu_pc !== 32'h30) begin failures++; $display("FAIL prio_id got=%0h exp=30", bus.bpu_pc); end
    endtask

    // Redirect coinciding with addr_ok: accepted, killed, PC from redirect.
    task automatic test_req_redirect_hs();
        bus.icache_addr_ok = 1'b1;
        bus.bpu_next_pc    = 32'h999;
        bus.id_flush       = 1'b1;
        bus.id_pc          = 32'h40;
        #1;
        checks++; if (bus.install !== 1'b1) begin failures++; $display("FAIL rhs_install got=%0h exp=1", bus.install); end
        tick();
        bus.icache_addr_ok = 1'b0;
        bus.id_flush       = 1'b0;
        #1;
        checks++; if (bus.icache_req !== 1'b0) begin failures++; $display("FAIL rhs_wait_req got=%0h exp=0", bus.icache_req); end
        checks++; if (bus.bpu_pc !== 32'h40) begin failures++; $display("FAIL rhs_pc got=%0h exp=40", bus.bpu_pc); end
        bus.icache_data_ok = 1'b1;
        tick();
        bus.icache_data_ok = 1'b0;
        #1;
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL rhs_fq_valid got=%0h exp=0", bus.fq_valid); end
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL rhs_req got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h40) begin failures++; $display("FAIL rhs_addr got=%0h exp=40", bus.icache_addr); end
    endtask

    // Fetch-queue stall in HOLD: outputs frozen, no new request.
    task automatic test_backpressure();
        bus.icache_addr_ok = 1'b1;
        bus.bpu_next_pc    = 32'h50;
        bus.bpu_pc_valid   = 4'b0111;
        bus.bpu_pc_is_jump = 4'b0100;
        tick();
        bus.icache_addr_ok = 1'b0;
        bus.bpu_pc_valid   = 4'h0;
        bus.bpu_pc_is_jump = 4'h0;
        bus.icache_data_ok = 1'b1;
        bus.icache_rdata   = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        tick();
        bus.icache_data_ok = 1'b0;
        bus.icache_rdata   = 128'h0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.fq_valid !== 1'b1) begin failures++; $display("FAIL bp_fq_valid cyc=%0d got=%0h exp=1", i, bus.fq_valid); end
            checks++; if (bus.fq_pc !== 32'h40 || bus.fq_mask !== 4'b0111 || bus.fq_jump !== 4'b0100) begin failures++; $display("FAIL bp_slot cyc=%0d pc=%0h mask=%0h jump=%0h exp=40/7/4", i, bus.fq_pc, bus.fq_mask, bus.fq_jump); end
            checks++; if (bus.fq_inst !== {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}) begin failures++; $display("FAIL bp_inst cyc=%0d got=%0h", i, bus.fq_inst); end
            checks++; if (bus.icache_req !== 1'b0) begin failures++; $display("FAIL bp_req cyc=%0d got=%0h exp=0", i, bus.icache_req); end
            tick();
        end
        bus.fq_ready = 1'b1;
        tick();
        bus.fq_ready = 1'b0;
        #1;
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL bp_req_after got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL bp_fq_valid_after got=%0h exp=0", bus.fq_valid); end
        checks++; if (bus.icache_addr !== 32'h50) begin failures++; $display("FAIL bp_addr_after got=%0h exp=50", bus.icache_addr); end
    endtask

    // Redirect while holding a group: group dropped, fq_valid low at once.
    task automatic test_hold_redirect();
        bus.icache_addr_ok = 1'b1;
        bus.bpu_next_pc    = 32'h60;
        tick();
        bus.icache_addr_ok = 1'b0;
        bus.icache_data_ok = 1'b1;
        tick();
        bus.icache_data_ok = 1'b0;
        bus.bpu_flush      = 1'b1;
        bus.bpu_jump_pc    = 32'h70;
        #1;
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL hr_fq_valid_now got=%0h exp=0", bus.fq_valid); end
        tick();
        bus.bpu_flush = 1'b0;
        #1;
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL hr_fq_valid got=%0h exp=0", bus.fq_valid); end
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL hr_req got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h70) begin failures++; $display("FAIL hr_addr got=%0h exp=70", bus.icache_addr); end
    endtask

    // data_ok and a redirect in the same WAIT cycle: data discarded.
    task automatic test_wait_data_redirect();
        bus.icache_addr_ok = 1'b1;
        bus.bpu_next_pc    = 32'h80;
        tick();
        bus.icache_addr_ok = 1'b0;
        bus.icache_data_ok = 1'b1;
        bus.ex_redirect    = 1'b1;
        bus.ex_pc          = 32'h94;
        tick();
        bus.icache_data_ok = 1'b0;
        bus.ex_redirect    = 1'b0;
        #1;
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL wd_fq_valid got=%0h exp=0", bus.fq_valid); end
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL wd_req got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h90) begin failures++; $display("FAIL wd_addr got=%0h exp=90", bus.icache_addr); end
        checks++; if (bus.bpu_pc !== 32'h94) begin failures++; $display("FAIL wd_bpu_pc got=%0h exp=94", bus.bpu_pc); end
    endtask

    // Reset while a request is outstanding; its late data_ok is ignored.
    task automatic test_reset_midrequest();
        bus.icache_addr_ok = 1'b1;
        bus.bpu_next_pc    = 32'ha0;
        tick();
        bus.icache_addr_ok = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL rm_req got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h1c000000) begin failures++; $display("FAIL rm_addr got=%0h exp=1c000000", bus.icache_addr); end
        bus.icache_data_ok = 1'b1;
        tick();
        bus.icache_data_ok = 1'b0;
        #1;
        checks++; if (bus.fq_valid !== 1'b0) begin failures++; $display("FAIL rm_fq_valid got=%0h exp=0", bus.fq_valid); end
        checks++; if (bus.icache_req !== 1'b1) begin failures++; $display("FAIL rm_req2 got=%0h exp=1", bus.icache_req); end
        checks++; if (bus.icache_addr !== 32'h1c000000) begin failures++; $display("FAIL rm_addr2 got=%0h exp=1c000000", bus.icache_addr); end
    endtask

`ifdef PCGEN_PERF_CNT_EN
    task automatic test_perf_counters();
        apply_reset();
        #1;
        checks++; if (perf_groups !== 32'd0 || perf_redirects !== 32'd0) begin failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_groups, perf_redirects); end
        deliver_group(32'h1c000010, 128'h1);
        deliver_group(32'h1c000020, 128'h2);
        deliver_group(32'h1c000030, 128'h3);
        bus.id_flush = 1'b1;
        bus.id_pc    = 32'h1c000400;
        tick();
        bus.id_flush = 1'b0;
        #1;
        checks++; if (perf_groups !== 32'd3) begin failures++; $display("FAIL perf_groups got=%0d exp=3", perf_groups); end
        checks++; if (perf_redirects !== 32'd1) begin failures++; $display("FAIL perf_redirects got=%0d exp=1", perf_redirects); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_follow();
        test_wait_kill();
        test_priority();
        test_req_redirect_hs();
        test_backpressure();
        test_hold_redirect();
        test_wait_data_redirect();
        test_reset_midrequest();
`ifdef PCGEN_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
